parity_stream_accum: RTL and testbench

//  Streaming parity generator: accumulates even-parity (XOR of all bits) over a frame of

---
 rtl/parity_pkg.sv | 8 +
 rtl/parity_reduce.sv | 9 +
 rtl/parity_stream_accum.sv | 118 +++++++++++
 tb/tb_parity_stream_accum.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types for the framed parity accumulator: FSM state encoding and counter sizing.
package parity_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  function automatic int f_cnt_w(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one WIDTH-bit word to its parity bit.
module parity_reduce #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);
  assign o_parity = ^i_data;
endmodule

// File: rtl/parity_stream_accum.sv
// Framed streaming parity accumulator: XORs word parities over a frame, then holds one
// result on a valid/ready output. Optional expected-parity check under PARITY_CHECK_EN.
module parity_stream_accum
  import parity_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int MAX_WORDS = 64,
  localparam int CNT_W     = f_cnt_w(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             odd_mode,
`ifdef PARITY_CHECK_EN
  input  logic             exp_parity,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_words,
  output logic             out_trunc
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t           r_state;
  logic             r_acc, r_odd, r_in_ready, r_out_valid, r_parity, r_trunc;
  logic [CNT_W-1:0] r_cnt, r_words;
`ifdef PARITY_CHECK_EN
  logic             r_err;
`endif

  logic             w_wpar, w_beat, w_first, w_close, w_acc_nxt, w_odd_nxt, w_par_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  parity_reduce #(.WIDTH(WIDTH)) u_reduce (
    .i_data   (in_data),
    .o_parity (w_wpar)
  );

  // First beat of a frame reloads the accumulator and latches the parity sense.
  assign w_beat    = in_valid && r_in_ready;
  assign w_first   = (r_state == S_IDLE);
  assign w_acc_nxt = w_first ? w_wpar : (r_acc ^ w_wpar);
  assign w_odd_nxt = w_first ? odd_mode : r_odd;
  assign w_cnt_nxt = w_first ? CNT_W'(1) : (r_cnt + CNT_W'(1));
  assign w_close   = in_last || (w_cnt_nxt == MAX_CNT);
  assign w_par_nxt = w_acc_nxt ^ w_odd_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= 1'b0;
      r_odd       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_parity    <= 1'b0;
      r_words     <= '0;
      r_trunc     <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_beat) begin
            r_acc <= w_acc_nxt;
            r_odd <= w_odd_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_close) begin
              r_state     <= S_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_parity    <= w_par_nxt;
              r_words     <= w_cnt_nxt;
              r_trunc     <= !in_last;
`ifdef PARITY_CHECK_EN
              r_err       <= w_par_nxt ^ exp_parity;
`endif
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          // No bypass: the pop cycle itself never accepts a new beat.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_acc       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_parity    <= 1'b0;
            r_words     <= '0;
            r_trunc     <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_err       <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_parity = r_parity;
  assign out_words  = r_words;
  assign out_trunc  = r_trunc;
`ifdef PARITY_CHECK_EN
  assign out_err    = r_err;
`endif
endmodule

// File: tb/tb_parity_stream_accum.sv
// Directed + randomized self-checking bench for parity_stream_accum (WIDTH=16, MAX_WORDS=4).
module tb_parity_stream_accum;
  localparam int W  = 16;
  localparam int MW = 4;
  localparam int CW = $clog2(MW + 1);

  logic          clk = 1'b0;
  logic          rst, in_valid, in_last, odd_mode, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid, out_parity, out_trunc;
  logic [CW-1:0] out_words;
`ifdef PARITY_CHECK_EN
  logic          exp_parity, out_err;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  parity_stream_accum #(.WIDTH(W), .MAX_WORDS(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .odd_mode   (odd_mode),
`ifdef PARITY_CHECK_EN
    .exp_parity (exp_parity),
    .out_err    (out_err),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_words  (out_words),
    .out_trunc  (out_trunc)
  );

  // Called at a negedge; presents one beat across the next posedge, returns at the following negedge.
  task automatic send(input logic [W-1:0] d, input logic l);
    in_data = d; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; odd_mode = 1'b0; out_ready = 1'b0;
`ifdef PARITY_CHECK_EN
    exp_parity = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_total++; if (out_valid !== 1'b0)  $display("FAIL rst_valid got %0b want 0", out_valid);   else n_pass++;
    n_total++; if (in_ready !== 1'b1)   $display("FAIL rst_ready got %0b want 1", in_ready);    else n_pass++;
    n_total++; if (out_parity !== 1'b0) $display("FAIL rst_parity got %0b want 0", out_parity); else n_pass++;
    n_total++; if (out_words !== 3'd0)  $display("FAIL rst_words got %0d want 0", out_words);   else n_pass++;
    n_total++; if (out_trunc !== 1'b0)  $display("FAIL rst_trunc got %0b want 0", out_trunc);   else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    odd_mode = 1'b0;
    send(16'hA5A5, 1'b1);
    n_total++; if (out_valid !== 1'b1)  $display("FAIL single_valid got %0b want 1", out_valid);   else n_pass++;
    n_total++; if (out_parity !== 1'b0) $display("FAIL single_parity got %0b want 0", out_parity); else n_pass++;
    n_total++; if (out_words !== 3'd1)  $display("FAIL single_words got %0d want 1", out_words);   else n_pass++;
    n_total++; if (out_trunc !== 1'b0)  $display("FAIL single_trunc got %0b want 0", out_trunc);   else n_pass++;
    n_total++; if (in_ready !== 1'b0)   $display("FAIL single_ready got %0b want 0", in_ready);    else n_pass++;
    pop();
    n_total++; if (out_valid !== 1'b0)  $display("FAIL single_pop got %0b want 0", out_valid);     else n_pass++;
  endtask

  // odd_mode flips after the first beat; the frame must keep the value sampled on beat one.
  task automatic test_odd_mode();
    odd_mode = 1'b1;
    send(16'h0001, 1'b0);
    odd_mode = 1'b0;
    send(16'h0003, 1'b0);
    send(16'h0007, 1'b1);
    n_total++; if (out_parity !== 1'b1) $display("FAIL odd_parity got %0b want 1", out_parity); else n_pass++;
    n_total++; if (out_words !== 3'd3)  $display("FAIL odd_words got %0d want 3", out_words);   else n_pass++;
    pop();
  endtask

  task automatic test_trunc();
    odd_mode = 1'b0;
    repeat (4) send(16'h0001, 1'b0);
    n_total++; if (out_valid !== 1'b1)  $display("FAIL trunc_valid got %0b want 1", out_valid);   else n_pass++;
    n_total++; if (out_words !== 3'd4)  $display("FAIL trunc_words got %0d want 4", out_words);   else n_pass++;
    n_total++; if (out_parity !== 1'b0) $display("FAIL trunc_parity got %0b want 0", out_parity); else n_pass++;
    n_total++; if (out_trunc !== 1'b1)  $display("FAIL trunc_flag got %0b want 1", out_trunc);    else n_pass++;
    // Fifth word presented during the pop cycle must wait one more cycle.
    in_data = 16'h0001; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++; if (out_valid !== 1'b0)  $display("FAIL trunc_popped got %0b want 0", out_valid);  else n_pass++;
    n_total++; if (in_ready !== 1'b1)   $display("FAIL trunc_reready got %0b want 1", in_ready);  else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    n_total++; if (out_words !== 3'd1)  $display("FAIL frame2_words got %0d want 1", out_words);  else n_pass++;
    n_total++; if (out_parity !== 1'b1) $display("FAIL frame2_parity got %0b want 1", out_parity); else n_pass++;
    n_total++; if (out_trunc !== 1'b0)  $display("FAIL frame2_trunc got %0b want 0", out_trunc);  else n_pass++;
    pop();
    // in_last on the MAX_WORDS-th beat is a normal close.
    repeat (3) send(16'h0003, 1'b0);
    send(16'h0001, 1'b1);
    n_total++; if (out_words !== 3'd4)  $display("FAIL lastmax_words got %0d want 4", out_words);  else n_pass++;
    n_total++; if (out_trunc !== 1'b0)  $display("FAIL lastmax_trunc got %0b want 0", out_trunc);  else n_pass++;
    n_total++; if (out_parity !== 1'b1) $display("FAIL lastmax_parity got %0b want 1", out_parity); else n_pass++;
    pop();
  endtask

  task automatic test_hold();
    odd_mode = 1'b0;
    send(16'h0003, 1'b1);
    in_data = 16'hFFFF; in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL hold_hs[%0d] got valid=%0b ready=%0b want 1/0", i, out_valid, in_ready); else n_pass++;
      n_total++; if (out_words !== 3'd1 || out_parity !== 1'b0)
        $display("FAIL hold_data[%0d] got words=%0d par=%0b want 1/0", i, out_words, out_parity); else n_pass++;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    pop();
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL hold_release got valid=%0b ready=%0b want 0/1", out_valid, in_ready); else n_pass++;
    n_total++; if (out_words !== 3'd0 || out_parity !== 1'b0)
      $display("FAIL hold_idle_zero got words=%0d par=%0b want 0/0", out_words, out_parity); else n_pass++;
  endtask

  task automatic test_gap();
    odd_mode = 1'b0;
    send(16'h0001, 1'b0);
    in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_last = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL gap_valid got %0b want 0", out_valid); else n_pass++;
    send(16'h0000, 1'b1);
    n_total++; if (out_words !== 3'd2 || out_parity !== 1'b1)
      $display("FAIL gap_result got words=%0d par=%0b want 2/1", out_words, out_parity); else n_pass++;
    pop();
  endtask

  task automatic test_mid_reset();
    odd_mode = 1'b0;
    send(16'h0001, 1'b0);
    send(16'h0001, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midrst got valid=%0b ready=%0b want 0/1", out_valid, in_ready); else n_pass++;
    send(16'hFFFF, 1'b0);
    send(16'h0001, 1'b1);
    n_total++; if (out_parity !== 1'b1) $display("FAIL midrst_parity got %0b want 1", out_parity); else n_pass++;
    n_total++; if (out_words !== 3'd2)  $display("FAIL midrst_words got %0d want 2", out_words);   else n_pass++;
    // Reset while holding a result drops it.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL holdrst got valid=%0b ready=%0b want 0/1", out_valid, in_ready); else n_pass++;
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_check();
    odd_mode = 1'b0;
    exp_parity = 1'b0;
    send(16'h0001, 1'b1);
    n_total++; if (out_err !== 1'b1) $display("FAIL err_mismatch got %0b want 1", out_err); else n_pass++;
    pop();
    exp_parity = 1'b1;
    send(16'h0001, 1'b1);
    exp_parity = 1'b0;
    n_total++; if (out_err !== 1'b0) $display("FAIL err_match got %0b want 0", out_err); else n_pass++;
    pop();
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] d;
    logic         par, odd, lst;
    int           len, cnt;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 6);
      odd = 1'($urandom_range(0, 1));
      odd_mode = odd; par = 1'b0; cnt = 0; lst = 1'b0;
      for (int k = 0; k < len; k++) begin
        d = W'($urandom);
        lst = (k == len - 1);
        par ^= ^d;
        send(d, lst);
        odd_mode = 1'($urandom_range(0, 1));
        cnt++;
        if (lst || cnt == MW) break;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      n_total++; if (out_parity !== (par ^ odd))
        $display("FAIL rnd_parity[%0d] got %0b want %0b", f, out_parity, par ^ odd); else n_pass++;
      n_total++; if (out_words !== CW'(cnt))
        $display("FAIL rnd_words[%0d] got %0d want %0d", f, out_words, cnt); else n_pass++;
      n_total++; if (out_trunc !== !lst)
        $display("FAIL rnd_trunc[%0d] got %0b want %0b", f, out_trunc, !lst); else n_pass++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pop();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_odd_mode();
    test_trunc();
    test_hold();
    test_gap();
    test_mid_reset();
`ifdef PARITY_CHECK_EN
    test_check();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
